x_shift_serdes: RTL

X_SHIFT_SERDES -- requirements
Module: x_shift_serdes

---
 rtl/x_shift_pkg.sv | 16 +
 rtl/x_shift_serdes.sv | 91 +++++++++
 2 files changed

// File: rtl/x_shift_pkg.sv
// rtl/x_shift_pkg.sv - shared types for the x_shift_serdes shift register
//
// Purpose: holds the FSM state type used by x_shift_serdes.
// Ports:   none (package).
`timescale 1ns/1ps

package x_shift_pkg;

  // IDLE: receive mode, parallel load accepted.
  // TX:   a loaded word is being shifted out.
  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_e;

endpackage

// File: rtl/x_shift_serdes.sv
// rtl/x_shift_serdes.sv - bidirectional serializer/deserializer shift register
//
// Purpose: WIDTH-bit shift register usable as a transmitter (parallel load,
//          serial out) or receiver (serial in, parallel frame out).
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          shift one bit this cycle
//   i_dir         0 = shift toward MSB (MSB first out), 1 = toward LSB
//   i_in          serial data in
//   o_out         serial data out (combinational on i_dir)
//   i_load_valid  parallel load request
//   o_load_ready  load accepted when high together with i_load_valid
//   i_load_data   parallel load word
//   o_par         current shift register contents
//   o_par_valid   one-cycle pulse after a WIDTH-bit frame completes
//   o_busy        high while a loaded word is being transmitted
`timescale 1ns/1ps

module x_shift_serdes
  import x_shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_in,
  output logic             o_out,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_par,
  output logic             o_par_valid,
  output logic             o_busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             par_valid_q, par_valid_d;
  logic             load_fire;

  assign o_load_ready = (state_q == IDLE);
  assign o_busy       = (state_q == TX);
  assign load_fire    = i_load_valid && o_load_ready;

  assign o_out       = i_dir ? shift_q[0] : shift_q[WIDTH-1];
  assign o_par       = shift_q;
  assign o_par_valid = par_valid_q;

  always_comb begin
    shift_d     = shift_q;
    count_d     = count_q;
    state_d     = state_q;
    par_valid_d = 1'b0;
    if (load_fire) begin
      // A load takes priority over a shift in the same cycle.
      shift_d = i_load_data;
      count_d = '0;
      state_d = TX;
    end else if (i_en) begin
      shift_d = i_dir ? {i_in, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], i_in};
      if (count_q == CNT_W'(WIDTH - 1)) begin
        // Frame boundary: pulse next cycle; a transmit frame ends here too.
        count_d     = '0;
        par_valid_d = 1'b1;
        state_d     = IDLE;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      par_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      par_valid_q <= par_valid_d;
    end
  end

endmodule
